// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/response bus between the LSU memory stage (master) and data memory (slave).
interface lsu_mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [3:0]        mem_req_be;
  logic [ADDR_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [ADDR_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// MIPS memory-access stage: one instruction in flight, load align/extend, LL/SC link tracking.
//   state | meaning
//   IDLE  | ready for a new ALU result
//   REQ   | memory request presented, waiting for mem_req_ready
//   WAIT  | load issued, waiting for mem_rsp_valid
//   RESP  | result presented to writeback, waiting for out_ready
module lsu_mem_stage #(
  parameter int          ADDR_W    = 32,
  parameter logic [5:0]  SC_OPCODE = 6'h38
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] store_data,
  input  logic [4:0]        dest_reg,
  lsu_mem_stage_if.master   mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_data,
  output logic [4:0]        out_dest,
  output logic              out_we,
  output logic              out_exc
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [5:0]          op_q, op_d;
  logic [3:0]          be_q, be_d;
  logic                we_q, we_d, owe_q, owe_d, exc_q, exc_d;
  logic [4:0]          dest_q, dest_d;
  logic                link_valid_q, link_valid_d;
  logic [ADDR_W-3:0]   link_addr_q, link_addr_d;

  logic                in_load, in_store, misalign, link_hit, req_link_hit;
  logic [7:0]          rsp_byte;
  logic [15:0]         rsp_half;
  logic [ADDR_W-1:0]   load_val;

  assign in_load  = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LL};
  assign in_store = opcode inside {OP_SB, OP_SH, OP_SW, SC_OPCODE};
  assign misalign = ((opcode inside {OP_LH, OP_LHU, OP_SH}) && alu_result[0]) ||
                    ((opcode inside {OP_LW, OP_LL, OP_SW, SC_OPCODE}) && (alu_result[1:0] != 2'b00));
  assign link_hit     = link_valid_q && (link_addr_q == alu_result[ADDR_W-1:2]);
  assign req_link_hit = link_valid_q && (link_addr_q == addr_q[ADDR_W-1:2]);

  always_comb begin
    rsp_byte = mem.mem_rsp_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    rsp_byte = mem.mem_rsp_rdata[15:8];
      2'd2:    rsp_byte = mem.mem_rsp_rdata[23:16];
      2'd3:    rsp_byte = mem.mem_rsp_rdata[31:24];
      default: rsp_byte = mem.mem_rsp_rdata[7:0];
    endcase
    rsp_half = addr_q[1] ? mem.mem_rsp_rdata[31:16] : mem.mem_rsp_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{(ADDR_W-8){rsp_byte[7]}}, rsp_byte};
      OP_LBU:  load_val = {{(ADDR_W-8){1'b0}}, rsp_byte};
      OP_LH:   load_val = {{(ADDR_W-16){rsp_half[15]}}, rsp_half};
      OP_LHU:  load_val = {{(ADDR_W-16){1'b0}}, rsp_half};
      default: load_val = mem.mem_rsp_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    op_d         = op_q;
    be_d         = be_q;
    we_d         = we_q;
    owe_d        = owe_q;
    exc_d        = exc_q;
    dest_d       = dest_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        addr_d  = alu_result;
        op_d    = opcode;
        dest_d  = dest_reg;
        data_d  = '0;
        owe_d   = 1'b0;
        exc_d   = 1'b0;
        we_d    = in_store;
        case (opcode)
          OP_SB:   begin be_d = 4'b0001 << alu_result[1:0]; wdata_d = {(ADDR_W/8){store_data[7:0]}}; end
          OP_SH:   begin be_d = 4'b0011 << alu_result[1:0]; wdata_d = {(ADDR_W/16){store_data[15:0]}}; end
          default: begin be_d = 4'hF; wdata_d = store_data; end
        endcase
        // SC consumes the link whatever its outcome; the success decision uses the pre-clear value
        if (opcode == SC_OPCODE) link_valid_d = 1'b0;
        if (!(in_load || in_store)) begin
          data_d  = alu_result;
          owe_d   = 1'b1;
          state_d = RESP;
        end else if (misalign) begin
          exc_d   = 1'b1;
          state_d = RESP;
        end else if ((opcode == SC_OPCODE) && !link_hit) begin
          owe_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (mem.mem_req_ready) begin
        if (we_q) begin
          if (req_link_hit) link_valid_d = 1'b0;
          if (op_q == SC_OPCODE) begin
            data_d = {{(ADDR_W-1){1'b0}}, 1'b1};
            owe_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (mem.mem_rsp_valid) begin
        data_d = load_val;
        owe_d  = 1'b1;
        if (op_q == OP_LL) begin
          link_valid_d = 1'b1;
          link_addr_d  = addr_q[ADDR_W-1:2];
        end
        state_d = RESP;
      end
      RESP: if (out_ready) begin
        exc_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      op_q         <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      owe_q        <= 1'b0;
      exc_q        <= 1'b0;
      dest_q       <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      op_q         <= op_d;
      be_q         <= be_d;
      we_q         <= we_d;
      owe_q        <= owe_d;
      exc_q        <= exc_d;
      dest_q       <= dest_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  // Request fields are forced to zero outside REQ so the bus is quiet between transactions
  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_req_we    = mem.mem_req_valid && we_q;
  assign mem.mem_req_addr  = mem.mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.mem_req_be    = mem.mem_req_valid ? be_q : 4'h0;
  assign mem.mem_req_wdata = mem.mem_req_valid ? wdata_q : '0;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign out_data  = data_q;
  assign out_dest  = dest_q;
  assign out_we    = owe_q;
  assign out_exc   = exc_q;
endmodule
